// File: rtl/dsp_chain_sop2_dot_ctrl.sv
// Dot-product sequencer for a 2-stage fp16_sop2_mult DSP chain.
// Each accepted beat drives 8 fp16 operands plus the running fp32 accumulator
// into the chain head, then waits LAT cycles for the chain tail result.
// Optional build macro: DOT_CTRL_BEAT_OUT_EN (emit partial results per beat).
module dsp_chain_sop2_dot_ctrl #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned LEN_W = 8,
  parameter logic [10:0] MODE  = 11'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [15:0]      top_a1,
  output logic [15:0]      top_b1,
  output logic [15:0]      bot_a1,
  output logic [15:0]      bot_b1,
  output logic [15:0]      top_a2,
  output logic [15:0]      top_b2,
  output logic [15:0]      bot_a2,
  output logic [15:0]      bot_b2,
  output logic [31:0]      fp32_in,
  output logic [10:0]      mode_sigs,
  input  logic [31:0]      dsp_result,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] beat_nxt;
  logic [3:0]       wait_cnt;
  logic [31:0]      acc;
  logic             issue;
  logic             capture;
  logic             last_beat;
  logic             start_vec;
  logic             start_zero;

  assign mode_sigs = MODE;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides start and any pending handshake
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    issue      = 1'b0;
    capture    = 1'b0;
    last_beat  = 1'b0;
    start_vec  = 1'b0;
    start_zero = 1'b0;
    beat_nxt   = beat_cnt + LEN_W'(1);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (vec_len != '0) begin
            start_vec = 1'b1;
            state_nxt = ISSUE;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            issue     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (wait_cnt == 4'd1) begin
          capture   = 1'b1;
          last_beat = (beat_nxt == len_q);
          state_nxt = last_beat ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, accumulator, counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      acc       <= '0;
      top_a1    <= '0;
      top_b1    <= '0;
      bot_a1    <= '0;
      bot_b1    <= '0;
      top_a2    <= '0;
      top_b2    <= '0;
      bot_a2    <= '0;
      bot_b2    <= '0;
      fp32_in   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;

      if (start_vec) begin
        len_q    <= vec_len;
        beat_cnt <= '0;
        acc      <= '0;
      end

      if (start_zero) begin
        out_valid <= 1'b1;
        out_data  <= '0;
        out_last  <= 1'b1;
        done      <= 1'b1;
      end

      if (issue) begin
        top_a1   <= in_data[15:0];
        top_b1   <= in_data[31:16];
        bot_a1   <= in_data[47:32];
        bot_b1   <= in_data[63:48];
        top_a2   <= in_data[79:64];
        top_b2   <= in_data[95:80];
        bot_a2   <= in_data[111:96];
        bot_b2   <= in_data[127:112];
        fp32_in  <= acc;
        wait_cnt <= 4'(LAT);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Final result is taken straight from the chain so it appears the
      // cycle after the sample edge, together with the acc update.
      if (capture) begin
        acc      <= dsp_result;
        beat_cnt <= beat_nxt;
        if (last_beat) begin
          out_valid <= 1'b1;
          out_data  <= dsp_result;
          out_last  <= 1'b1;
          done      <= 1'b1;
        end else begin
`ifdef DOT_CTRL_BEAT_OUT_EN
          out_valid <= 1'b1;
          out_data  <= dsp_result;
`endif
        end
      end

      if (abort && state != IDLE) begin
        acc      <= '0;
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_chain_sop2_dot_ctrl.sv
// Scoreboard bench for dsp_chain_sop2_dot_ctrl with a behavioural LAT-cycle
// DSP chain model: result = fp32_in + sum of the four fp16 products.
module tb_dsp_chain_sop2_dot_ctrl;

  localparam int unsigned LAT   = 4;
  localparam int unsigned LEN_W = 8;
  localparam logic [10:0] MODE  = 11'h5A5;

  localparam logic [15:0] H_ONE = 16'h3C00;
  localparam logic [15:0] H_TWO = 16'h4000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] vec_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [15:0]      top_a1, top_b1, bot_a1, bot_b1;
  logic [15:0]      top_a2, top_b2, bot_a2, bot_b2;
  logic [31:0]      fp32_in;
  logic [10:0]      mode_sigs;
  logic [31:0]      dsp_result;
  logic             out_valid;
  logic [31:0]      out_data;
  logic             out_last;
  logic             done;

  int checks   = 0;
  int failures = 0;

  logic [32:0] res_q[$];  // {last, data}
  logic [31:0] fp_q[$];   // expected fp32_in per accepted beat
  logic        pend_hs = 1'b0;

  dsp_chain_sop2_dot_ctrl #(
    .LAT  (LAT),
    .LEN_W(LEN_W),
    .MODE (MODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .vec_len   (vec_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .top_a1    (top_a1),
    .top_b1    (top_b1),
    .bot_a1    (bot_a1),
    .bot_b1    (bot_b1),
    .top_a2    (top_a2),
    .top_b2    (top_b2),
    .bot_a2    (bot_a2),
    .bot_b2    (bot_b2),
    .fp32_in   (fp32_in),
    .mode_sigs (mode_sigs),
    .dsp_result(dsp_result),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ---------------- DSP chain model ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real v;
    if (f[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic       s;
    int         e;
    real        m;
    logic [7:0] eb;
    logic [22:0] fr;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    eb = 8'(e);
    fr = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, eb, fr};
  endfunction

  logic [31:0] chain_f;
  logic [31:0] pipe [LAT-1];

  always_comb begin
    chain_f = r2f(f2r(fp32_in) + h2r(top_a1) * h2r(top_b1) + h2r(bot_a1) * h2r(bot_b1)
                  + h2r(top_a2) * h2r(top_b2) + h2r(bot_a2) * h2r(bot_b2));
  end

  always @(posedge clk) begin
    pipe[0] <= chain_f;
    for (int i = 1; i < int'(LAT) - 1; i++) pipe[i] <= pipe[i-1];
  end

  assign dsp_result = pipe[LAT-2];

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: issued beats and produced results are compared against the queues
  always @(negedge clk) begin
    if (pend_hs) begin
      if (fp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_issue actual fp32_in=%h required=no issue", fp32_in);
      end else begin
        check32("fp32_in", fp32_in, fp_q.pop_front());
      end
    end
    pend_hs = in_valid && in_ready;
    if (out_valid) begin
      if (res_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out actual=%h required=no output", out_data);
      end else begin
        logic [32:0] e;
        e = res_q.pop_front();
        check32("out_data", out_data, e[31:0]);
        check32("out_last", 32'(out_last), 32'(e[32]));
        check32("done_with_last", 32'(done), 32'(e[32]));
      end
    end else if (done) begin
      checks++; failures++;
      $display("FAIL done_without_valid actual=1 required=0");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [15:0] v);
    in_data = {8{v}};
  endtask

  task automatic do_start(input int len);
    vec_len = LEN_W'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic push_partial(input logic [31:0] d);
`ifdef DOT_CTRL_BEAT_OUT_EN
    res_q.push_back({1'b0, d});
`else
    if (d === 32'hx) res_q.push_back({1'b0, d});
`endif
  endtask

  // mode 0: in_valid held high; mode 1: in_valid toggles every cycle
  task automatic wait_done(input int mode, output int cycles, output int readies);
    bit got = 1'b0;
    cycles  = 1;
    readies = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) readies++;
      if (done) begin got = 1'b1; break; end
      tick();
      cycles++;
      if (mode == 1) in_valid = ~in_valid;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no done required=done within budget");
    end
    tick();
  endtask

  function automatic logic [31:0] out_or();
    return {31'h0, busy | in_ready | out_valid | out_last | done}
         | {16'h0, top_a1 | top_b1 | bot_a1 | bot_b1 | top_a2 | top_b2 | bot_a2 | bot_b2}
         | fp32_in | out_data;
  endfunction

  int cyc;
  int rdy;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    vec_len = '0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_outputs", out_or(), 32'h0);
    check32("reset_mode", 32'(mode_sigs), 32'(MODE));
    reset = 1'b0;
    tick();

    // single beat of 1.0 operands -> 4.0
    set_ops(H_ONE); in_valid = 1'b1;
    fp_q.push_back(32'h0);
    res_q.push_back({1'b1, 32'h40800000});
    do_start(1);
    wait_done(0, cyc, rdy);
    check32("single_latency", 32'(cyc), 32'(LAT + 2));

    // three beats -> 12.0
    fp_q.push_back(32'h0); fp_q.push_back(32'h40800000); fp_q.push_back(32'h41000000);
    push_partial(32'h40800000); push_partial(32'h41000000);
    res_q.push_back({1'b1, 32'h41400000});
    do_start(3);
    wait_done(0, cyc, rdy);
    check32("accum_latency", 32'(cyc), 32'((LAT + 1) * 3 + 1));
    check32("accum_ready_cycles", 32'(rdy), 32'd3);

    // backpressure, then toggling in_valid -> 32.0
    set_ops(H_TWO); in_valid = 1'b0;
    fp_q.push_back(32'h0); fp_q.push_back(32'h41800000);
    push_partial(32'h41800000);
    res_q.push_back({1'b1, 32'h42000000});
    do_start(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stall_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b1;
    wait_done(1, cyc, rdy);
    in_valid = 1'b0;

    // zero length
    res_q.push_back({1'b1, 32'h0});
    do_start(0);
    @(negedge clk);
    check32("zero_done", 32'(done), 32'd1);
    check32("zero_busy", 32'(busy), 32'd0);
    tick();

    // start during WAIT is ignored
    set_ops(H_ONE); in_valid = 1'b1;
    fp_q.push_back(32'h0);
    res_q.push_back({1'b1, 32'h40800000});
    do_start(1);
    tick();
    vec_len = LEN_W'(3); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, cyc, rdy);
    repeat (3) tick();
    check32("start_ignored_idle", 32'(busy), 32'd0);

    // abort during WAIT of beat 2 of 4
    fp_q.push_back(32'h0); fp_q.push_back(32'h40800000);
    push_partial(32'h40800000);
    do_start(4);
    repeat (8) tick();
    check32("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_no_done", 32'(done), 32'd0);
    repeat (8) tick();
    check32("abort_idle_after", 32'(busy), 32'd0);

    // asynchronous reset while in ISSUE
    do_start(2);
    tick();
    #2 reset = 1'b1;
    #1;
    check32("async_reset_outputs", out_or(), 32'h0);
    check32("async_reset_mode", 32'(mode_sigs), 32'(MODE));
    @(negedge clk);
    reset = 1'b0;
    tick();

    // a following single beat runs normally
    in_valid = 1'b1;
    fp_q.push_back(32'h0);
    res_q.push_back({1'b1, 32'h40800000});
    do_start(1);
    wait_done(0, cyc, rdy);
    in_valid = 1'b0;
    check32("post_reset_latency", 32'(cyc), 32'(LAT + 2));

    repeat (4) tick();
    check32("results_drained", 32'(res_q.size()), 32'd0);
    check32("issues_drained", 32'(fp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
